// File: rtl/plane_raster_walker.sv
// Plane raster walker: walks a triangle bbox row-major and emits x*ddx + y*ddy + c per pixel.
// Optional build macro INTERP_CLAMP_EN clamps pix_interp to the 8-bit colour channel range.
module plane_raster_walker #(
    parameter int FRAC_BITS = 8,
    parameter int COORD_W   = 11
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_ddx,
    input  logic [31:0]        in_ddy,
    input  logic [31:0]        in_c,
    input  logic [COORD_W-1:0] in_x_min,
    input  logic [COORD_W-1:0] in_x_max,
    input  logic [COORD_W-1:0] in_y_min,
    input  logic [COORD_W-1:0] in_y_max,
    input  logic               abort,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic [31:0]        pix_interp,
    output logic               pix_last,
    output logic               tri_done
);

`ifdef INTERP_CLAMP_EN
    localparam bit CLAMP_EN = 1'b1;
`else
    localparam bit CLAMP_EN = 1'b0;
`endif
    localparam logic [31:0] CLAMP_MAX = 32'((255 << FRAC_BITS) | ((1 << FRAC_BITS) - 1));

    typedef enum logic [1:0] {IDLE, SETUP, WALK} state_t;

    typedef struct packed {
        logic [31:0]        ddx;
        logic [31:0]        ddy;
        logic [31:0]        c;
        logic [COORD_W-1:0] x_min;
        logic [COORD_W-1:0] x_max;
        logic [COORD_W-1:0] y_min;
        logic [COORD_W-1:0] y_max;
    } bundle_t;

    state_t             state_q, state_d;
    bundle_t            bun_q, bun_d;
    logic [31:0]        row_acc_q, row_acc_d;
    logic [31:0]        interp_q, interp_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;

    logic               fire;
    logic               at_x_end;
    logic               at_y_end;
    logic               empty_box;
    logic [31:0]        setup_acc;
    logic [31:0]        next_row;

    assign fire      = valid_q && pix_ready;
    assign at_x_end  = (x_q == bun_q.x_max);
    assign at_y_end  = (y_q == bun_q.y_max);
    assign empty_box = (bun_q.x_min > bun_q.x_max) || (bun_q.y_min > bun_q.y_max);
    // Low 32 bits of the product are sign-agnostic, so a plain 32-bit multiply gives the wrapped result.
    assign setup_acc = bun_q.ddx * 32'(bun_q.x_min) + bun_q.ddy * 32'(bun_q.y_min) + bun_q.c;
    assign next_row  = row_acc_q + bun_q.ddy;

    // The done cycle blocks acceptance so a new bundle never overlaps the tri_done pulse.
    assign in_ready  = (state_q == IDLE) && !done_q;
    assign pix_valid = valid_q;
    assign pix_x     = x_q;
    assign pix_y     = y_q;
    assign pix_last  = valid_q && at_x_end && at_y_end;
    assign tri_done  = done_q;

    always_comb begin
        state_d   = state_q;
        bun_d     = bun_q;
        row_acc_d = row_acc_q;
        interp_d  = interp_q;
        x_d       = x_q;
        y_d       = y_q;
        valid_d   = valid_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    bun_d   = '{ddx: in_ddx, ddy: in_ddy, c: in_c,
                                x_min: in_x_min, x_max: in_x_max,
                                y_min: in_y_min, y_max: in_y_max};
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (abort || empty_box) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    row_acc_d = setup_acc;
                    interp_d  = setup_acc;
                    x_d       = bun_q.x_min;
                    y_d       = bun_q.y_min;
                    valid_d   = 1'b1;
                    state_d   = WALK;
                end
            end
            WALK: begin
                if (abort) begin
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (fire) begin
                    if (!at_x_end) begin
                        x_d      = x_q + 1'b1;
                        interp_d = interp_q + bun_q.ddx;
                    end else if (!at_y_end) begin
                        x_d       = bun_q.x_min;
                        y_d       = y_q + 1'b1;
                        row_acc_d = next_row;
                        interp_d  = next_row;
                    end else begin
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            bun_q     <= '0;
            row_acc_q <= '0;
            interp_q  <= '0;
            x_q       <= '0;
            y_q       <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bun_q     <= bun_d;
            row_acc_q <= row_acc_d;
            interp_q  <= interp_d;
            x_q       <= x_d;
            y_q       <= y_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
        end
    end

    // Clamping touches only the output; the accumulators keep wrapping underneath.
    always_comb begin
        pix_interp = interp_q;
        if (CLAMP_EN) begin
            if (interp_q[31])
                pix_interp = '0;
            else if (interp_q > CLAMP_MAX)
                pix_interp = CLAMP_MAX;
        end
    end

endmodule
